// File: rtl/input_vc_buffer_pkg.sv
// Shared flit field layout, flit type codes and write-side framing states
// for the router input VC buffer.
package input_vc_buffer_pkg;

    localparam int NUM_VC    = 4;
    localparam int DEPTH     = 4;
    localparam int PTR_W     = 2;
    localparam int FLIT_W    = 32;

    localparam int TYPE_MSB  = 31;
    localparam int TYPE_LSB  = 30;
    localparam int VC_MSB    = 29;
    localparam int VC_LSB    = 28;
    localparam int PAYLOAD_W = 28;

    typedef enum logic [1:0] {
        FLIT_INV  = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/vc_fifo.sv
// Single-clock show-ahead FIFO; the front entry is driven combinationally
// and reads as zero while empty so stale storage never leaks out.
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] dout_o
);

    logic [W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic           wr_fire, rd_fire;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    // Full is sampled before the pop, so a write into a full FIFO is lost
    // even when the same cycle frees a slot.
    assign wr_fire = wr_i && !full_o;
    assign rd_fire = rd_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/input_vc_buffer.sv
// Router input buffer: demuxes link flits into per-VC FIFOs, checks packet
// framing per VC, and exposes the selected VC's head flit to the allocator.
module input_vc_buffer
    import input_vc_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_data,
    input  logic [FLIT_W-1:0] data_in,
    output logic [NUM_VC-1:0] vc_full,
    input  logic              rd,
    input  logic [1:0]        rd_vc,
    output logic [FLIT_W-1:0] dout,
    output logic [NUM_VC-1:0] vc_empty,
    output logic [NUM_VC-1:0] vc_head,
    output logic              overflow_err,
    output logic              proto_err,
    output logic [NUM_VC-1:0] vc_state_dbg_o
);

    flit_type_e        in_type;
    logic [1:0]        in_vc;
    logic              in_valid;
    logic [NUM_VC-1:0] wr_en, rd_en, fifo_full, fifo_empty;
    logic [FLIT_W-1:0] fifo_dout [NUM_VC];
    frame_state_e      state_q [NUM_VC];
    frame_state_e      state_d [NUM_VC];
    logic              proto_hit, drop;
    logic              overflow_err_q, proto_err_q;

    assign in_type  = flit_type_e'(data_in[TYPE_MSB:TYPE_LSB]);
    assign in_vc    = data_in[VC_MSB:VC_LSB];
    assign in_valid = valid_data && (in_type != FLIT_INV);
    assign drop     = in_valid && fifo_full[in_vc];

    // Framing only observes flits that were actually stored.
    always_comb begin
        proto_hit = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_en[v]   = in_valid && (in_vc == 2'(v)) && !fifo_full[v];
            rd_en[v]   = rd && (rd_vc == 2'(v));
            state_d[v] = state_q[v];
            if (wr_en[v]) begin
                case (state_q[v])
                    ST_IDLE: begin
                        if (in_type == FLIT_HEAD) state_d[v] = ST_IN_PKT;
                        else                      proto_hit  = 1'b1;
                    end
                    ST_IN_PKT: begin
                        if (in_type == FLIT_TAIL)      state_d[v] = ST_IDLE;
                        else if (in_type == FLIT_HEAD) proto_hit  = 1'b1;
                    end
                    default: state_d[v] = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) state_q[v] <= ST_IDLE;
            overflow_err_q <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) state_q[v] <= state_d[v];
            overflow_err_q <= overflow_err_q | drop;
            proto_err_q    <= proto_err_q | proto_hit;
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_fifo #(
            .DEPTH (DEPTH),
            .PTR_W (PTR_W),
            .W     (FLIT_W)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (reset),
            .wr_i      (wr_en[g]),
            .wr_data_i (data_in),
            .rd_i      (rd_en[g]),
            .full_o    (fifo_full[g]),
            .empty_o   (fifo_empty[g]),
            .dout_o    (fifo_dout[g])
        );

        assign vc_head[g] = !fifo_empty[g] &&
                            (fifo_dout[g][TYPE_MSB:TYPE_LSB] == FLIT_HEAD);
        assign vc_state_dbg_o[g] = (state_q[g] == ST_IN_PKT);
    end

    assign vc_full      = fifo_full;
    assign vc_empty     = fifo_empty;
    assign dout         = fifo_dout[rd_vc];
    assign overflow_err = overflow_err_q;
    assign proto_err    = proto_err_q;

endmodule
